// File: rtl/round_timer_pkg.sv
// Shared widths, FSM encoding and saturating helpers for the round timer.
// Combinational definitions only; no latency, no flow control.
package round_timer_pkg;

   localparam int TIME_W  = 12;
   localparam int SCORE_W = 24;
   localparam int LEVEL_W = 10;

   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_RUN     = 2'd1;
   localparam state_t ST_BONUS   = 2'd2;
   localparam state_t ST_TIMEOUT = 2'd3;

   // The carry bit of the widened sum is the overflow flag.
   function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
   endfunction

   function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
      return (lvl == LEVEL_MAX) ? lvl : lvl + 1'b1;
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: tick is high combinationally in the last count of each period.
// Latency: tick every CLK_HZ counting cycles; hold freezes the count, clear forces it to 0.
module sec_tick_gen #(
   parameter int CLK_HZ = 65_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int              CNT_W   = $clog2(CLK_HZ);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = !clear && !hold && (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/round_timer_ctrl.sv
// Level countdown, bonus drain and score sequencer; all outputs registered, one cycle per drained second.
// No backpressure; optional TIMER_PAUSE_EN makes pause freeze the prescaler while running.
module round_timer_ctrl
   import round_timer_pkg::*;
#(
   parameter int CLK_HZ        = 65_000_000,
   parameter int INIT_TIME     = 60,
   parameter int BONUS_PER_SEC = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               level_clear,
   input  logic               pause,
   output logic [TIME_W-1:0]  time_left,
   output logic [SCORE_W-1:0] score,
   output logic [LEVEL_W-1:0] level,
   output logic               running,
   output logic               bonus_busy,
   output logic               time_up
);

   localparam logic [TIME_W-1:0]  INIT_T = TIME_W'(INIT_TIME);
   localparam logic [SCORE_W-1:0] BONUS  = SCORE_W'(BONUS_PER_SEC);

   state_t             state;
   state_t             state_nxt;
   logic [TIME_W-1:0]  time_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic [LEVEL_W-1:0] level_nxt;
   logic               time_up_nxt;
   logic               tick;
   logic               tick_hold;

`ifdef TIMER_PAUSE_EN
   assign tick_hold = pause;
`else
   logic pause_unused;
   assign pause_unused = pause;
   assign tick_hold    = 1'b0;
`endif

   // Outside RUN the prescaler sits at 0, so every (re)entry into RUN starts a full second.
   sec_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_sec_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (state != ST_RUN),
      .hold  (tick_hold),
      .tick  (tick)
   );

   always_comb begin
      state_nxt   = state;
      time_nxt    = time_left;
      score_nxt   = score;
      level_nxt   = level;
      time_up_nxt = 1'b0;
      case (state)
         ST_IDLE, ST_TIMEOUT: begin
            if (start) begin
               state_nxt = ST_RUN;
               time_nxt  = INIT_T;
               score_nxt = '0;
               level_nxt = LEVEL_W'(1);
            end
         end
         ST_RUN: begin
            // A clear in the same cycle as a tick wins and the tick is dropped.
            if (level_clear) begin
               state_nxt = ST_BONUS;
            end else if (tick && (time_left != '0)) begin
               time_nxt = time_left - 1'b1;
               if (time_left == TIME_W'(1)) begin
                  state_nxt   = ST_TIMEOUT;
                  time_up_nxt = 1'b1;
               end
            end
         end
         ST_BONUS: begin
            if (time_left != '0) begin
               score_nxt = score_add(score, BONUS);
               time_nxt  = time_left - 1'b1;
            end else begin
               level_nxt = level_inc(level);
               time_nxt  = INIT_T;
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         time_left  <= INIT_T;
         score      <= '0;
         level      <= '0;
         running    <= 1'b0;
         bonus_busy <= 1'b0;
         time_up    <= 1'b0;
      end else begin
         state      <= state_nxt;
         time_left  <= time_nxt;
         score      <= score_nxt;
         level      <= level_nxt;
         running    <= (state_nxt == ST_RUN);
         bonus_busy <= (state_nxt == ST_BONUS);
         time_up    <= time_up_nxt;
      end
   end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: directed vector table, async reset cases, randomized run against a reference model,
// and a second large-parameter instance driven to score saturation.
module tb_round_timer_ctrl;

   localparam int CLK_HZ    = 4;
   localparam int INIT_TIME = 3;
   localparam int BONUS     = 10;
   localparam int SCORE_MAX = 16777215;
   localparam int LEVEL_MAX = 1023;

   localparam int S_INIT  = 4095;
   localparam int S_BONUS = 255;

`ifdef TIMER_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_RUN = 1, M_BONUS = 2, M_TOUT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        level_clear = 1'b0;
   logic        pause = 1'b0;
   logic [11:0] time_left;
   logic [23:0] score;
   logic [9:0]  level;
   logic        running, bonus_busy, time_up;

   logic        s_rst = 1'b1;
   logic        s_start = 1'b0;
   logic        s_clear = 1'b0;
   logic        s_pause = 1'b0;
   logic [11:0] s_time_left;
   logic [23:0] s_score;
   logic [9:0]  s_level;
   logic        s_running, s_bonus_busy, s_time_up;

   int n_checks = 0;
   int n_errors = 0;
   bit sat_done = 1'b0;
   logic rp = 1'b0;

   int m_st, m_t, m_s, m_l, m_cnt;
   bit m_up;

   typedef struct {
      logic st, lc, ps;
      int   n, t, s, l;
      logic run, bb, up;
   } vec_t;

   vec_t vt[20];

   always #5 clk = ~clk;

   round_timer_ctrl #(.CLK_HZ(CLK_HZ), .INIT_TIME(INIT_TIME), .BONUS_PER_SEC(BONUS)) dut (
      .clk(clk), .rst(rst), .start(start), .level_clear(level_clear), .pause(pause),
      .time_left(time_left), .score(score), .level(level),
      .running(running), .bonus_busy(bonus_busy), .time_up(time_up)
   );

   round_timer_ctrl #(.CLK_HZ(100000), .INIT_TIME(S_INIT), .BONUS_PER_SEC(S_BONUS)) dut_sat (
      .clk(clk), .rst(s_rst), .start(s_start), .level_clear(s_clear), .pause(s_pause),
      .time_left(s_time_left), .score(s_score), .level(s_level),
      .running(s_running), .bonus_busy(s_bonus_busy), .time_up(s_time_up)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic lc, input logic ps, input int n,
                               input int t, input int s, input int l,
                               input logic run, input logic bb, input logic up);
      vec_t v;
      v.st = st; v.lc = lc; v.ps = ps; v.n = n;
      v.t = t; v.s = s; v.l = l; v.run = run; v.bb = bb; v.up = up;
      return v;
   endfunction

   task automatic m_reset();
      m_st = M_IDLE; m_t = INIT_TIME; m_s = 0; m_l = 0; m_cnt = 0; m_up = 1'b0;
   endtask

   // Game rules applied once per clock: seconds counted by a cycle counter within RUN.
   task automatic m_step(input logic st, input logic lc, input logic ps);
      bit frz;
      frz  = PAUSE_EN && ps;
      m_up = 1'b0;
      case (m_st)
         M_IDLE, M_TOUT: begin
            if (st) begin
               m_st = M_RUN; m_t = INIT_TIME; m_s = 0; m_l = 1; m_cnt = 0;
            end
         end
         M_RUN: begin
            if (lc) begin
               m_st = M_BONUS;
            end else if (!frz) begin
               if (m_cnt == CLK_HZ - 1) begin
                  m_cnt = 0;
                  m_t   = m_t - 1;
                  if (m_t == 0) begin
                     m_st = M_TOUT;
                     m_up = 1'b1;
                  end
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
         end
         default: begin
            if (m_t > 0) begin
               m_s = (m_s + BONUS > SCORE_MAX) ? SCORE_MAX : m_s + BONUS;
               m_t = m_t - 1;
            end else begin
               m_l   = (m_l < LEVEL_MAX) ? m_l + 1 : LEVEL_MAX;
               m_t   = INIT_TIME;
               m_cnt = 0;
               m_st  = M_RUN;
            end
         end
      endcase
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".time_left"},  32'(time_left),  32'(m_t));
      chk({tag, ".score"},      32'(score),      32'(m_s));
      chk({tag, ".level"},      32'(level),      32'(m_l));
      chk({tag, ".running"},    32'(running),    32'(m_st == M_RUN));
      chk({tag, ".bonus_busy"}, 32'(bonus_busy), 32'(m_st == M_BONUS));
      chk({tag, ".time_up"},    32'(time_up),    32'(m_up));
   endtask

   task automatic cycle(input string tag, input logic st, input logic lc, input logic ps);
      start = st; level_clear = lc; pause = ps;
      @(posedge clk);
      m_step(st, lc, ps);
      #1;
      check_model(tag);
   endtask

   // Entered just after a rising edge: rst rises mid-cycle and outputs are checked before any edge.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      check_model(tag);
      chk({tag, ".abs_time_left"}, 32'(time_left), 32'(INIT_TIME));
      chk({tag, ".abs_score"},     32'(score),     32'd0);
      @(negedge clk);
      rst = 1'b0; start = 1'b0; level_clear = 1'b0;
   endtask

   initial begin : main_proc
      vt[0]  = mk(1, 0, 0, 1,  3,  0, 1, 1, 0, 0);
      vt[1]  = mk(0, 0, 0, 3,  3,  0, 1, 1, 0, 0);
      vt[2]  = mk(0, 0, 0, 1,  2,  0, 1, 1, 0, 0);
      vt[3]  = mk(0, 0, 0, 4,  1,  0, 1, 1, 0, 0);
      vt[4]  = mk(0, 0, 0, 4,  0,  0, 1, 0, 0, 1);
      vt[5]  = mk(0, 0, 0, 1,  0,  0, 1, 0, 0, 0);
      vt[6]  = mk(0, 1, 0, 1,  0,  0, 1, 0, 0, 0);
      vt[7]  = mk(1, 0, 0, 1,  3,  0, 1, 1, 0, 0);
      vt[8]  = mk(0, 0, 0, 4,  2,  0, 1, 1, 0, 0);
      vt[9]  = mk(0, 1, 0, 1,  2,  0, 1, 0, 1, 0);
      vt[10] = mk(0, 0, 0, 1,  1, 10, 1, 0, 1, 0);
      vt[11] = mk(0, 0, 0, 1,  0, 20, 1, 0, 1, 0);
      vt[12] = mk(0, 0, 0, 1,  3, 20, 2, 1, 0, 0);
      vt[13] = mk(0, 0, 0, 4,  2, 20, 2, 1, 0, 0);
      vt[14] = mk(0, 0, 0, 3,  2, 20, 2, 1, 0, 0);
      vt[15] = mk(0, 1, 0, 1,  2, 20, 2, 0, 1, 0);
      vt[16] = mk(0, 0, 0, 2,  0, 40, 2, 0, 1, 0);
      vt[17] = mk(0, 0, 0, 1,  3, 40, 3, 1, 0, 0);
      vt[18] = mk(0, 0, 1, 10, PAUSE_EN ? 3 : 1, 40, 3, 1, 0, 0);
      vt[19] = mk(1, 0, 0, 1,  PAUSE_EN ? 3 : 1, 40, 3, 1, 0, 0);

      @(posedge clk);
      #1;
      async_reset("reset");
      cycle("idle_clear", 1'b0, 1'b1, 1'b0);

      foreach (vt[k]) begin
         for (int c = 0; c < vt[k].n; c++) cycle($sformatf("vec%0d.model", k), vt[k].st, vt[k].lc, vt[k].ps);
         chk($sformatf("vec%0d.time_left", k),  32'(time_left),  32'(vt[k].t));
         chk($sformatf("vec%0d.score", k),      32'(score),      32'(vt[k].s));
         chk($sformatf("vec%0d.level", k),      32'(level),      32'(vt[k].l));
         chk($sformatf("vec%0d.running", k),    32'(running),    32'(vt[k].run));
         chk($sformatf("vec%0d.bonus_busy", k), 32'(bonus_busy), 32'(vt[k].bb));
         chk($sformatf("vec%0d.time_up", k),    32'(time_up),    32'(vt[k].up));
      end

      cycle("bonus_enter", 1'b0, 1'b1, 1'b0);
      cycle("bonus_drain", 1'b0, 1'b0, 1'b0);
      async_reset("bonus_rst");
      for (int c = 0; c < 3; c++) cycle("post_rst_idle", 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
         if ($urandom_range(0, 7) == 0) rp = ~rp;
         cycle("rand", 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 14) == 0), rp);
      end
      start = 1'b0; level_clear = 1'b0; pause = 1'b0;

      for (int i = 0; i < 80000 && !sat_done; i++) @(negedge clk);
      chk("sat.finished", 32'(sat_done), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : sat_proc
      int n;
      int exp_s;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      chk("sat.running", 32'(s_running), 32'd1);
      exp_s = 0;
      for (int lv = 1; lv <= 17; lv++) begin
         @(negedge clk);
         s_clear = 1'b1;
         @(negedge clk);
         s_clear = 1'b0;
         chk("sat.bonus_entry", 32'(s_bonus_busy), 32'd1);
         n = 0;
         while (s_bonus_busy && n < 5000) begin
            @(negedge clk);
            n++;
         end
         chk("sat.drain_done", 32'(s_bonus_busy), 32'd0);
         exp_s = (exp_s + S_INIT * S_BONUS > SCORE_MAX) ? SCORE_MAX : exp_s + S_INIT * S_BONUS;
         chk($sformatf("sat.score_lv%0d", lv), 32'(s_score), 32'(exp_s));
         chk($sformatf("sat.level_lv%0d", lv), 32'(s_level), 32'(lv + 1));
         chk("sat.time_left", 32'(s_time_left), 32'(S_INIT));
      end
      sat_done = 1'b1;
   end

endmodule
